// File: rtl/bus_arb_2to1_if.sv
// Bus bundle for the 2:1 round-robin arbiter.
// Carries the two upstream valid/ready requester channels and the shared
// downstream channel. The arbiter connects through the 'slave' modport.
// The surrounding environment (the requesters plus the downstream sink)
// connects through the 'master' modport.
interface bus_arb_2to1_if #(
    parameter int WIDTH = 64
);
    // Requester 0
    logic [WIDTH-1:0] m0_data;
    logic             m0_last;
    logic             m0_valid;
    logic             m0_ready;

    // Requester 1
    logic [WIDTH-1:0] m1_data;
    logic             m1_last;
    logic             m1_valid;
    logic             m1_ready;

    // Shared downstream channel
    logic [WIDTH-1:0] s_data;
    logic             s_src;
    logic             s_last;
    logic             s_valid;
    logic             s_ready;

    // Arbiter side: consumes requests, drives readies and the downstream beat
    modport slave (
        input  m0_data, m0_last, m0_valid,
        output m0_ready,
        input  m1_data, m1_last, m1_valid,
        output m1_ready,
        output s_data, s_src, s_last, s_valid,
        input  s_ready
    );

    // Environment side: drives requests, consumes readies and the downstream beat
    modport master (
        output m0_data, m0_last, m0_valid,
        input  m0_ready,
        output m1_data, m1_last, m1_valid,
        input  m1_ready,
        input  s_data, s_src, s_last, s_valid,
        output s_ready
    );
endinterface

// File: rtl/bus_arb_2to1.sv
// Round-robin 2:1 packet arbiter over a valid/ready channel.
// A grant is held from the first beat of a packet until its last beat is
// accepted, so packets from the two requesters never interleave. The
// round-robin pointer rr_last moves only when a packet completes.
// Optional build macro BUS_ARB_PERF_EN adds saturating performance counters
// (perf_m0_beats, perf_m1_beats, perf_conflict).
module bus_arb_2to1 #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    bus_arb_2to1_if.slave    bus
`ifdef BUS_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_m0_beats,
    output logic [CNT_W-1:0] perf_m1_beats,
    output logic [CNT_W-1:0] perf_conflict
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       rr_last;
    logic       rr_last_next;

    logic       pick_valid;
    logic       pick;
    logic       grant_valid;
    logic       grant;
    logic       g_valid;
    logic       g_last;
    logic       accept;

    // Tie-break pick for IDLE: a lone requester wins, otherwise whoever did not finish last
    always_comb begin
        pick_valid = 1'b0;
        pick       = rr_last;
        unique case ({bus.m1_valid, bus.m0_valid})
            2'b01: begin
                pick_valid = 1'b1;
                pick       = 1'b0;
            end
            2'b10: begin
                pick_valid = 1'b1;
                pick       = 1'b1;
            end
            2'b11: begin
                pick_valid = 1'b1;
                pick       = ~rr_last;
            end
            default: begin
                pick_valid = 1'b0;
                pick       = rr_last;
            end
        endcase
    end

    // Effective grant: a locked packet owns the channel, otherwise take the pick; reset blocks all grants
    always_comb begin
        grant_valid = 1'b0;
        grant       = rr_last;
        unique case (state)
            LOCK0: begin
                grant_valid = 1'b1;
                grant       = 1'b0;
            end
            LOCK1: begin
                grant_valid = 1'b1;
                grant       = 1'b1;
            end
            default: begin
                grant_valid = pick_valid;
                grant       = pick;
            end
        endcase
        if (rst) begin
            grant_valid = 1'b0;
            grant       = rr_last;
        end
    end

    // Granted requester's handshake fields, selected by the effective grant
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        if (grant_valid) begin
            g_valid = grant ? bus.m1_valid : bus.m0_valid;
            g_last  = grant ? bus.m1_last  : bus.m0_last;
        end
        accept = g_valid & bus.s_ready;
    end

    // Zero-latency passthrough of the granted requester; the loser sees ready low
    always_comb begin
        bus.s_valid  = 1'b0;
        bus.s_src    = rr_last;
        bus.s_last   = 1'b0;
        bus.s_data   = grant ? bus.m1_data : bus.m0_data;
        bus.m0_ready = 1'b0;
        bus.m1_ready = 1'b0;
        if (grant_valid) begin
            bus.s_valid = g_valid;
            bus.s_src   = grant;
            bus.s_last  = g_last;
            if (grant) begin
                bus.m1_ready = bus.s_ready;
            end else begin
                bus.m0_ready = bus.s_ready;
            end
        end
    end

    // Next-state and round-robin update: lock on a non-final beat, release and rotate on the final beat
    always_comb begin
        state_next   = state;
        rr_last_next = rr_last;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (g_last) begin
                        rr_last_next = grant;
                    end else begin
                        state_next = grant ? LOCK1 : LOCK0;
                    end
                end
            end
            LOCK0, LOCK1: begin
                if (accept && g_last) begin
                    state_next   = IDLE;
                    rr_last_next = grant;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and round-robin pointer registers; reset abandons any lock and favours requester 0
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rr_last <= 1'b1;
        end else begin
            state   <= state_next;
            rr_last <= rr_last_next;
        end
    end

`ifdef BUS_ARB_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic acc_m0;
    logic acc_m1;
    logic conflict;

    // Per-cycle events feeding the counters; a conflict is a cycle where the non-granted requester waits
    always_comb begin
        acc_m0   = accept & ~grant;
        acc_m1   = accept &  grant;
        conflict = 1'b0;
        if (!rst && bus.m0_valid && bus.m1_valid) begin
            conflict = grant ? ~bus.m0_ready : ~bus.m1_ready;
        end
    end

    // Saturating event counters, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_m0_beats <= '0;
            perf_m1_beats <= '0;
            perf_conflict <= '0;
        end else begin
            if (acc_m0 && perf_m0_beats != CNT_MAX) begin
                perf_m0_beats <= perf_m0_beats + 1'b1;
            end
            if (acc_m1 && perf_m1_beats != CNT_MAX) begin
                perf_m1_beats <= perf_m1_beats + 1'b1;
            end
            if (conflict && perf_conflict != CNT_MAX) begin
                perf_conflict <= perf_conflict + 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/bus_arb_2to1.md
Name: bus_arb_2to1

Overview:
Round-robin arbiter that shares one downstream valid/ready channel between two upstream requesters. Typical use: instruction-fetch and load/store units feeding a common memory or refill port through their 2-deep FWFT queues. Transfers are packets of one or more beats, delimited by a last flag. A grant is held for the whole packet, so beats from the two sources never interleave.

Parameters:
WIDTH, 64, payload width of each beat
CNT_W, 32, width of performance counters (used only with the optional feature)

Ports:
clk  input  1  clock
rst  input  1  reset
m0_data  input  WIDTH  requester 0 beat payload
m0_last  input  1  requester 0 final beat of packet
m0_valid  input  1  requester 0 beat valid
m0_ready  output  1  requester 0 beat accepted when high with m0_valid
m1_data  input  WIDTH  requester 1 beat payload
m1_last  input  1  requester 1 final beat of packet
m1_valid  input  1  requester 1 beat valid
m1_ready  output  1  requester 1 beat accepted
s_data  output  WIDTH  granted beat payload
s_src  output  1  index of granted requester
s_last  output  1  granted beat is last of packet
s_valid  output  1  downstream beat valid
s_ready  input  1  downstream accepts beat
perf_m0_beats  output  CNT_W  beats accepted from requester 0 (macro only)
perf_m1_beats  output  CNT_W  beats accepted from requester 1 (macro only)
perf_conflict  output  CNT_W  cycles both requesters valid with one stalled (macro only)

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk.
- While rst is high: state=IDLE, rr_last=1 (requester 0 wins the first tie), and s_valid, m0_ready, m1_ready are all 0.
- State machine: IDLE, LOCK0, LOCK1.
- Combinational pick (used in IDLE):
  - Only m0_valid set -> 0.
  - Only m1_valid set -> 1.
  - Both set -> !rr_last.
  - Neither set -> no grant.
- Effective grant g:
  - LOCKx -> x.
  - IDLE -> the pick, if any.
- Zero-latency passthrough when a grant exists:
  - s_valid = mg_valid; s_data, s_last = granted requester's fields; s_src = g.
  - mg_ready = s_ready; the other requester's ready = 0.
- With no grant: s_valid=0, both readies 0, s_src = rr_last, s_data don't-care.
- Transitions:
  - IDLE, grant g, beat accepted (valid && ready) with last=0 -> LOCKg.
  - IDLE, grant g, beat accepted with last=1 -> stay IDLE; rr_last <= g.
  - LOCKg, beat accepted with last=1 -> IDLE; rr_last <= g.
  - LOCKg, otherwise -> hold, even if mg_valid drops mid-packet (bubble allowed; the other requester is not granted).
- rr_last is updated only on packet completion. A single-beat packet completes in one cycle.
- No bubble between packets: a new pick is made combinationally in the cycle after a last beat.
- Grant never switches while a beat is offered but not accepted (s_valid && !s_ready). Downstream sees a stable s_data/s_src until handshake.
- Requesters must hold data/last stable while valid && !ready. The arbiter does not check this.
- Reset mid-packet: lock is abandoned, state=IDLE, rr_last=1. Upstream/downstream must also be reset.
- s_ready does not depend on s_valid. No combinational path from s_ready to s_valid.

Optional Feature:
Macro: BUS_ARB_PERF_EN.
- Defined:
  - perf_m0_beats / perf_m1_beats increment on each accepted beat from that requester.
  - perf_conflict increments in each cycle where m0_valid && m1_valid and the non-granted requester is stalled.
  - All counters saturate at all-ones and clear to 0 on rst.
- Not defined: the three perf ports and their counters are not present.
- Arbitration behaviour is identical in both builds.

Test Plan:
- Reset, then m0 and m1 both valid with single-beat packets, s_ready=1 for 4 cycles -> s_src sequence 0,1,0,1; each ready high on alternate cycles.
- m0 sends a 3-beat packet (0xA0,0xA1,0xA2 with last on 0xA2) while m1 is valid throughout -> s_data A0,A1,A2 with s_src=0 and m1_ready=0; m1 is granted in the 4th cycle.
- m1 mid-packet in LOCK1, m1_valid drops 2 cycles, m0 valid -> s_valid=0 for 2 cycles, m0_ready stays 0, m1 resumes and completes before m0 is granted.
- Backpressure: s_ready=0 for 3 cycles with both valid in IDLE -> s_src and s_data are stable all 3 cycles; grant unchanged when s_ready rises.
- rst asserted in LOCK0 after 1 of 3 beats -> next cycle state IDLE; with both valid, m0 is granted (rr_last=1).
- BUS_ARB_PERF_EN defined, 5 contended alternating single-beat transfers -> perf_m0_beats=3, perf_m1_beats=2, perf_conflict=5; all counters 0 after rst.
